// File: rtl/register_file_sb.sv
// Integer register file: NREGS x XLEN storage, two combinational read ports,
// one clocked write port, same-cycle write forwarding and a busy scoreboard.
module register_file_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   A1,
  input  logic [AW-1:0]   A2,
  output logic [XLEN-1:0] RD1,
  output logic [XLEN-1:0] RD2,
  output logic            RDY1,
  output logic            RDY2,
  input  logic            WE3,
  input  logic [AW-1:0]   A3,
  input  logic [XLEN-1:0] WD3,
  input  logic            ISS,
  input  logic [AW-1:0]   IRD,
  output logic            HAZ
);

  localparam logic BYP = (BYPASS != 0);

  logic [XLEN-1:0] mem_q [NREGS];
  logic [XLEN-1:0] mem_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  logic [XLEN-1:0] rd1_s;
  logic [XLEN-1:0] rd2_s;
  logic            rdy1_s;
  logic            rdy2_s;

  function automatic logic fwd_hit(input logic [AW-1:0] a,
                                   input logic          we,
                                   input logic [AW-1:0] wa);
    return BYP && we && (wa == a);
  endfunction

  // Next state of storage and scoreboard; issue beats a simultaneous writeback.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (rst) begin
      for (int r = 0; r < NREGS; r++) begin
        mem_d[r] = {XLEN{1'b0}};
      end
      busy_d = {NREGS{1'b0}};
    end else begin
      if (WE3 && (A3 != {AW{1'b0}})) begin
        mem_d[A3] = WD3;
      end else begin
        mem_d[A3] = mem_q[A3];
      end
      for (int r = 1; r < NREGS; r++) begin
        if (ISS && (IRD == AW'(r))) begin
          busy_d[r] = 1'b1;
        end else if (WE3 && (A3 == AW'(r))) begin
          busy_d[r] = 1'b0;
        end else begin
          busy_d[r] = busy_q[r];
        end
      end
    end
    mem_d[0]  = {XLEN{1'b0}};
    busy_d[0] = 1'b0;
  end

  // State registers.
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    busy_q <= busy_d;
  end

  // Read port 1: x0 forced to zero, then forwarding, then stored value.
  always_comb begin
    rd1_s  = {XLEN{1'b0}};
    rdy1_s = 1'b1;
    if (A1 == {AW{1'b0}}) begin
      rd1_s  = {XLEN{1'b0}};
      rdy1_s = 1'b1;
    end else if (fwd_hit(A1, WE3, A3)) begin
      rd1_s  = WD3;
      rdy1_s = 1'b1;
    end else begin
      rd1_s  = mem_q[A1];
      rdy1_s = ~busy_q[A1];
    end
  end

  // Read port 2, same rules as port 1.
  always_comb begin
    rd2_s  = {XLEN{1'b0}};
    rdy2_s = 1'b1;
    if (A2 == {AW{1'b0}}) begin
      rd2_s  = {XLEN{1'b0}};
      rdy2_s = 1'b1;
    end else if (fwd_hit(A2, WE3, A3)) begin
      rd2_s  = WD3;
      rdy2_s = 1'b1;
    end else begin
      rd2_s  = mem_q[A2];
      rdy2_s = ~busy_q[A2];
    end
  end

  assign RD1  = rd1_s;
  assign RD2  = rd2_s;
  assign RDY1 = rdy1_s;
  assign RDY2 = rdy2_s;
  assign HAZ  = ~rdy1_s | ~rdy2_s;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed bench: BYPASS=1 and BYPASS=0 instances driven by the same stimulus.
module tb_register_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  a1, a2, a3, ird;
  logic        we3, iss;
  logic [31:0] wd3;
  logic [31:0] rd1, rd2, rd1_nb, rd2_nb;
  logic        rdy1, rdy2, haz, rdy1_nb, rdy2_nb, haz_nb;

  int n_checks = 0;
  int n_fail   = 0;

  register_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_byp (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1), .RD2(rd2),
    .RDY1(rdy1), .RDY2(rdy2), .WE3(we3), .A3(a3), .WD3(wd3),
    .ISS(iss), .IRD(ird), .HAZ(haz)
  );

  register_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .A1(a1), .A2(a2), .RD1(rd1_nb), .RD2(rd2_nb),
    .RDY1(rdy1_nb), .RDY2(rdy2_nb), .WE3(we3), .A3(a3), .WD3(wd3),
    .ISS(iss), .IRD(ird), .HAZ(haz_nb)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we3 = 1'b0; a3 = 5'd0; wd3 = 32'd0;
    iss = 1'b0; ird = 5'd0;
    a1 = 5'd0; a2 = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle();
    tick();
    rst = 1'b0;
    a1 = 5'd5; #1;
    n_checks++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL reset_init_rd1 got %h exp %h", rd1, 32'd0); end
    n_checks++; if (haz !== 1'b0) begin n_fail++; $display("FAIL reset_init_haz got %b exp 0", haz); end
    we3 = 1'b1; a3 = 5'd5; wd3 = 32'hDEADBEEF; iss = 1'b1; ird = 5'd7;
    tick();
    idle(); a1 = 5'd5; #1;
    n_checks++; if (rd1 !== 32'hDEADBEEF) begin n_fail++; $display("FAIL pre_reset_rd1 got %h exp %h", rd1, 32'hDEADBEEF); end
    a1 = 5'd7; #1;
    n_checks++; if (rdy1 !== 1'b0 || haz !== 1'b1) begin n_fail++; $display("FAIL pre_reset_busy got rdy1=%b haz=%b exp rdy1=0 haz=1", rdy1, haz); end
    rst = 1'b1;
    tick();
    rst = 1'b0; a1 = 5'd5; #1;
    n_checks++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL reset_clear_rd1 got %h exp %h", rd1, 32'd0); end
    a1 = 5'd7; #1;
    n_checks++; if (rdy1 !== 1'b1 || haz !== 1'b0) begin n_fail++; $display("FAIL reset_clear_busy got rdy1=%b haz=%b exp rdy1=1 haz=0", rdy1, haz); end
    // Write and issue presented during reset must be dropped.
    rst = 1'b1; we3 = 1'b1; a3 = 5'd4; wd3 = 32'h55; iss = 1'b1; ird = 5'd4;
    tick();
    rst = 1'b0; idle(); a1 = 5'd4; #1;
    n_checks++; if (rd1 !== 32'd0 || rdy1 !== 1'b1) begin n_fail++; $display("FAIL reset_ignores_we got rd1=%h rdy1=%b exp rd1=0 rdy1=1", rd1, rdy1); end
  endtask

  task automatic test_x0();
    idle();
    we3 = 1'b1; a3 = 5'd0; wd3 = 32'hFFFFFFFF; iss = 1'b1; ird = 5'd0; a1 = 5'd0; #1;
    n_checks++; if (rd1 !== 32'd0) begin n_fail++; $display("FAIL x0_no_fwd got %h exp %h", rd1, 32'd0); end
    tick();
    idle(); a1 = 5'd0; #1;
    n_checks++; if (rd1 !== 32'd0 || rd1_nb !== 32'd0) begin n_fail++; $display("FAIL x0_read got %h/%h exp 0", rd1, rd1_nb); end
    n_checks++; if (rdy1 !== 1'b1 || haz !== 1'b0 || haz_nb !== 1'b0) begin n_fail++; $display("FAIL x0_ready got rdy1=%b haz=%b haz_nb=%b exp 1/0/0", rdy1, haz, haz_nb); end
  endtask

  task automatic test_write_read();
    idle();
    a1 = 5'd9; a2 = 5'd9; a3 = 5'd9; we3 = 1'b1; wd3 = 32'h12345678; #1;
    n_checks++; if (rd1 !== 32'h12345678 || rd2 !== 32'h12345678) begin n_fail++; $display("FAIL wr_bypass got %h/%h exp %h", rd1, rd2, 32'h12345678); end
    n_checks++; if (rd1_nb !== 32'd0) begin n_fail++; $display("FAIL wr_nobypass_old got %h exp %h", rd1_nb, 32'd0); end
    tick();
    we3 = 1'b0; #1;
    n_checks++; if (rd1 !== 32'h12345678) begin n_fail++; $display("FAIL wr_after_byp got %h exp %h", rd1, 32'h12345678); end
    n_checks++; if (rd1_nb !== 32'h12345678 || rd2_nb !== 32'h12345678) begin n_fail++; $display("FAIL wr_after_nb got %h/%h exp %h", rd1_nb, rd2_nb, 32'h12345678); end
  endtask

  task automatic test_hazard();
    idle();
    iss = 1'b1; ird = 5'd3;
    tick();
    iss = 1'b0; a2 = 5'd3; #1;
    n_checks++; if (rdy2 !== 1'b0 || haz !== 1'b1) begin n_fail++; $display("FAIL haz_busy got rdy2=%b haz=%b exp 0/1", rdy2, haz); end
    tick();
    tick();
    n_checks++; if (rdy2_nb !== 1'b0 || haz_nb !== 1'b1) begin n_fail++; $display("FAIL haz_hold_nb got rdy2=%b haz=%b exp 0/1", rdy2_nb, haz_nb); end
    tick();
    we3 = 1'b1; a3 = 5'd3; wd3 = 32'hA5; #1;
    n_checks++; if (rdy2 !== 1'b1 || rd2 !== 32'hA5 || haz !== 1'b0) begin n_fail++; $display("FAIL haz_wb_byp got rdy2=%b rd2=%h haz=%b exp 1/a5/0", rdy2, rd2, haz); end
    n_checks++; if (rdy2_nb !== 1'b0 || haz_nb !== 1'b1 || rd2_nb !== 32'd0) begin n_fail++; $display("FAIL haz_wb_nb got rdy2=%b rd2=%h haz=%b exp 0/0/1", rdy2_nb, rd2_nb, haz_nb); end
    tick();
    we3 = 1'b0; #1;
    n_checks++; if (rdy2 !== 1'b1 || rdy2_nb !== 1'b1 || rd2_nb !== 32'hA5) begin n_fail++; $display("FAIL haz_cleared got rdy2=%b rdy2_nb=%b rd2_nb=%h exp 1/1/a5", rdy2, rdy2_nb, rd2_nb); end
  endtask

  task automatic test_simul_issue_wb();
    idle();
    iss = 1'b1; ird = 5'd6;
    tick();
    we3 = 1'b1; a3 = 5'd6; wd3 = 32'h77; a1 = 5'd6; #1;
    n_checks++; if (rdy1 !== 1'b1 || rdy1_nb !== 1'b0) begin n_fail++; $display("FAIL simul_same_cycle got rdy1=%b rdy1_nb=%b exp 1/0", rdy1, rdy1_nb); end
    tick();
    idle(); a1 = 5'd6; #1;
    n_checks++; if (rd1 !== 32'h77 || rd1_nb !== 32'h77) begin n_fail++; $display("FAIL simul_data got %h/%h exp %h", rd1, rd1_nb, 32'h77); end
    n_checks++; if (rdy1 !== 1'b0 || haz !== 1'b1) begin n_fail++; $display("FAIL simul_busy got rdy1=%b haz=%b exp 0/1", rdy1, haz); end
    we3 = 1'b1; a3 = 5'd6; wd3 = 32'h78;
    tick();
    idle(); a1 = 5'd6; #1;
    n_checks++; if (rdy1 !== 1'b1 || rd1 !== 32'h78) begin n_fail++; $display("FAIL simul_release got rdy1=%b rd1=%h exp 1/78", rdy1, rd1); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pat [4];
    pat[0] = 32'h0000_0001; pat[1] = 32'h8000_0000;
    pat[2] = 32'hFFFF_FFFF; pat[3] = 32'h5A5A_A5A5;
    idle();
    for (int i = 0; i < 4; i++) begin
      we3 = 1'b1; a3 = 5'(28 + i); wd3 = pat[i];
      tick();
    end
    idle();
    for (int i = 0; i < 4; i += 2) begin
      a1 = 5'(28 + i); a2 = 5'(29 + i); #1;
      n_checks++; if (rd1 !== pat[i] || rd2 !== pat[i+1]) begin n_fail++; $display("FAIL b2b_read%0d got %h/%h exp %h/%h", i, rd1, rd2, pat[i], pat[i+1]); end
      n_checks++; if (haz !== 1'b0) begin n_fail++; $display("FAIL b2b_haz%0d got %b exp 0", i, haz); end
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_write_read();
    test_hazard();
    test_simul_issue_wb();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
